// File: rtl/decoder_block_8to3_if.sv
// APB bus bundle for the 8-to-3 decoder slave.
interface decoder_block_8to3_if;
   logic       psel;
   logic       penable;
   logic       pwrite;
   logic [7:0] paddr;
   logic [7:0] pwdata;
   logic [7:0] prdata;
   logic       pready;
   logic       pslverr;

   modport master (output psel, penable, pwrite, paddr, pwdata,
                   input  prdata, pready, pslverr);
   modport slave  (input  psel, penable, pwrite, paddr, pwdata,
                   output prdata, pready, pslverr);
endinterface

// File: rtl/decoder_block_8to3.sv
// APB slave decoding an 8-bit code into a registered 3-bit index with valid/multi flags.
// Define DECODER_CNT_EN to add the read-only valid-decode counter at address 0x03.
module decoder_block_8to3 #(
   parameter int WAIT_STATES = 1
) (
   input  logic                  pclk,
   input  logic                  preset_n,
   decoder_block_8to3_if.slave   apb
);

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

   state_t     state, state_nxt;
   logic [2:0] wcnt, wcnt_nxt;
   logic       access, done, err, wr_en;
   logic [7:0] din, dout, rd_mux, dec_p0;
   logic [1:0] ctrl;
   logic       vld_p0;
`ifdef DECODER_CNT_EN
   logic [7:0] cnt;
`endif

   function automatic logic [7:0] decode(input logic [7:0] code, input logic lsb_first,
                                         input logic strict);
      logic [2:0] hi, lo;
      logic [3:0] ones;
      logic       multi;
      hi   = 3'd0;
      lo   = 3'd0;
      ones = 4'd0;
      for (int i = 0; i < 8; i++)
         if (code[i]) begin
            ones = ones + 4'd1;
            hi   = 3'(i);
         end
      for (int i = 7; i >= 0; i--)
         if (code[i]) lo = 3'(i);
      multi = (ones > 4'd1);
      if (code == 8'h00) return 8'h00;
      if (multi && strict) return 8'h40;
      return {1'b1, multi, 3'b000, lsb_first ? lo : hi};
   endfunction

   always_ff @(posedge pclk or negedge preset_n) begin
      if (!preset_n) begin
         state <= IDLE;
         wcnt  <= 3'd0;
      end else begin
         state <= state_nxt;
         wcnt  <= wcnt_nxt;
      end
   end

   // The FSM trails the bus by one cycle, so the first access cycle is seen in SETUP.
   always_comb begin
      state_nxt = state;
      wcnt_nxt  = wcnt;
      access    = apb.psel & apb.penable & (state != IDLE);
      done      = access & (wcnt == 3'(WAIT_STATES));
      case (state)
         IDLE: begin
            wcnt_nxt = 3'd0;
            if (apb.psel && !apb.penable) state_nxt = SETUP;
         end
         SETUP, ACCESS: begin
            if (!apb.psel || done) begin
               state_nxt = IDLE;
               wcnt_nxt  = 3'd0;
            end else if (access) begin
               state_nxt = ACCESS;
               wcnt_nxt  = wcnt + 3'd1;
            end else begin
               state_nxt = SETUP;
               wcnt_nxt  = 3'd0;
            end
         end
         default: begin
            state_nxt = IDLE;
            wcnt_nxt  = 3'd0;
         end
      endcase
   end

   always_comb begin
      err    = 1'b0;
      rd_mux = 8'h00;
      case (apb.paddr)
         8'h00: rd_mux = din;
         8'h01: begin
            rd_mux = dout;
            err    = apb.pwrite;
         end
         8'h02: rd_mux = {6'b000000, ctrl};
`ifdef DECODER_CNT_EN
         8'h03: begin
            rd_mux = cnt;
            err    = apb.pwrite;
         end
`endif
         default: err = 1'b1;
      endcase
   end

   assign apb.pready  = done;
   assign apb.pslverr = done & err;
   assign apb.prdata  = (done && !apb.pwrite && !err) ? rd_mux : 8'h00;
   assign wr_en       = done & apb.pwrite & ~err;
   assign dec_p0      = decode(din, ctrl[0], ctrl[1]);

   always_ff @(posedge pclk or negedge preset_n) begin
      if (!preset_n) begin
         din    <= 8'h00;
         ctrl   <= 2'b00;
         dout   <= 8'h00;
         vld_p0 <= 1'b0;
`ifdef DECODER_CNT_EN
         cnt    <= 8'h00;
`endif
      end else begin
         // p0: register write; a DIN write arms the decode stage
         vld_p0 <= wr_en && (apb.paddr == 8'h00);
         if (wr_en && apb.paddr == 8'h00) din  <= apb.pwdata;
         if (wr_en && apb.paddr == 8'h02) ctrl <= apb.pwdata[1:0];
         // p1: decode din with ctrl as it stands now
         if (vld_p0) dout <= dec_p0;
`ifdef DECODER_CNT_EN
         if (vld_p0 && dec_p0[7]) cnt <= cnt + 8'd1;
`endif
      end
   end

endmodule

// File: tb/tb_decoder_block_8to3.sv
// Directed scoreboard bench for decoder_block_8to3 (WAIT_STATES=1 main instance, 0 for timing).
module tb_decoder_block_8to3;
   logic pclk = 1'b0;
   logic preset_n;
   int   errors = 0;
   int   checks = 0;
   int   last_waits;

   typedef struct {
      string       tag;
      logic [15:0] exp;
   } item_t;
   item_t sb[$];

   always #5 pclk = ~pclk;

   decoder_block_8to3_if bus ();
   decoder_block_8to3_if bus0 ();

   decoder_block_8to3 #(.WAIT_STATES(1)) dut  (.pclk(pclk), .preset_n(preset_n), .apb(bus));
   decoder_block_8to3 #(.WAIT_STATES(0)) dut0 (.pclk(pclk), .preset_n(preset_n), .apb(bus0));

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; returns at a negedge with the bus idle (back-to-back capable).
   task automatic xfer(input logic wr, input logic [7:0] addr, input logic [7:0] wd,
                       input logic exp_err, input logic [7:0] exp_rd, input string tag);
      item_t it;
      int    n;
      logic  done;
      it.tag = tag;
      it.exp = {7'd0, exp_err, wr ? 8'h00 : exp_rd};
      sb.push_back(it);
      bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = wr; bus.paddr = addr; bus.pwdata = wd;
      @(negedge pclk);
      bus.penable = 1'b1;
      n = 0;
      done = 1'b0;
      while (!done && n < 20) begin
         #1;
         if (bus.pready) done = 1'b1;
         else begin
            check({tag, "_wait"}, {7'd0, bus.pslverr, bus.prdata}, 16'h0000);
            n++;
            @(negedge pclk);
         end
      end
      it = sb.pop_front();
      checks++;
      assert (done)
      else begin
         errors++;
         $error("FAIL %s_timeout waited=%0d required=completion", it.tag, n);
      end
      if (done) check(it.tag, {7'd0, bus.pslverr, bus.prdata}, it.exp);
      last_waits = n;
      @(negedge pclk);
      bus.psel = 1'b0; bus.penable = 1'b0;
   endtask

   task automatic wr(input logic [7:0] addr, input logic [7:0] d, input logic e, input string tag);
      xfer(1'b1, addr, d, e, 8'h00, tag);
   endtask

   task automatic rd(input logic [7:0] addr, input logic [7:0] d, input logic e, input string tag);
      xfer(1'b0, addr, 8'h00, e, d, tag);
   endtask

   task automatic pulse_reset();
      preset_n = 1'b0;
      @(negedge pclk);
      preset_n = 1'b1;
      @(negedge pclk);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] v;
      preset_n = 1'b0;
      bus.psel = 0; bus.penable = 0; bus.pwrite = 0; bus.paddr = 0; bus.pwdata = 0;
      bus0.psel = 0; bus0.penable = 0; bus0.pwrite = 0; bus0.paddr = 0; bus0.pwdata = 0;
      @(negedge pclk);
      @(negedge pclk);
      check("reset_outputs", {5'd0, bus.pready, bus.pslverr, 1'b0, bus.prdata}, 16'h0000);
      preset_n = 1'b1;
      @(negedge pclk);

      // Reset in the middle of a DIN write aborts it
      bus.psel = 1; bus.penable = 0; bus.pwrite = 1; bus.paddr = 8'h00; bus.pwdata = 8'h55;
      @(negedge pclk);
      bus.penable = 1;
      #1;
      check("abort_pre_ready", {15'd0, bus.pready}, 16'h0000);
      preset_n = 1'b0;
      #1;
      check("abort_in_reset", {5'd0, bus.pready, bus.pslverr, 1'b0, bus.prdata}, 16'h0000);
      @(negedge pclk);
      bus.psel = 0; bus.penable = 0;
      @(negedge pclk);
      preset_n = 1'b1;
      @(negedge pclk);
      rd(8'h00, 8'h00, 1'b0, "rst_din");
      rd(8'h01, 8'h00, 1'b0, "rst_dout");
      rd(8'h02, 8'h00, 1'b0, "rst_ctrl");

      // One-hot sweep
      for (int i = 0; i < 8; i++) begin
         v = 8'h01 << i;
         wr(8'h00, v, 1'b0, "oh_wr");
         rd(8'h01, 8'h80 | 8'(i), 1'b0, $sformatf("oh_rd%0d", i));
      end
      wr(8'h00, 8'h20, 1'b0, "oh20_wr");
      rd(8'h01, 8'h85, 1'b0, "oh20_rd");
      check("ws1_waits", 16'(last_waits), 16'd1);

      // Zero and multi-hot
      wr(8'h00, 8'h00, 1'b0, "zero_wr");
      rd(8'h01, 8'h00, 1'b0, "zero_rd");
      wr(8'h00, 8'h24, 1'b0, "mh_wr");
      rd(8'h01, 8'hC5, 1'b0, "mh_msb");
      wr(8'h02, 8'h01, 1'b0, "ctrl_lsb");
      wr(8'h00, 8'h24, 1'b0, "mh_wr2");
      rd(8'h01, 8'hC2, 1'b0, "mh_lsb");
      wr(8'h02, 8'h03, 1'b0, "ctrl_strict");
      rd(8'h01, 8'hC2, 1'b0, "ctrl_no_redecode");
      wr(8'h00, 8'h24, 1'b0, "mh_wr3");
      rd(8'h01, 8'h40, 1'b0, "mh_strict");

      // Errors
      rd(8'h09, 8'h00, 1'b1, "err_unmapped");
      wr(8'h01, 8'hFF, 1'b1, "err_ro_wr");
      rd(8'h01, 8'h40, 1'b0, "dout_unchanged");
      wr(8'h02, 8'hFF, 1'b0, "ctrl_ff");
      rd(8'h02, 8'h03, 1'b0, "ctrl_mask");
      wr(8'h02, 8'h00, 1'b0, "ctrl_clr");

      // Zero wait states: pready in the first access cycle
      bus0.psel = 1; bus0.pwrite = 1; bus0.paddr = 8'h00; bus0.pwdata = 8'h08;
      @(negedge pclk);
      bus0.penable = 1;
      #1;
      check("ws0_wr_ready", {14'd0, bus0.pready, bus0.pslverr}, 16'h0002);
      @(negedge pclk);
      bus0.penable = 0; bus0.pwrite = 0; bus0.paddr = 8'h01;
      @(negedge pclk);
      bus0.penable = 1;
      #1;
      check("ws0_rd", {6'd0, bus0.pready, bus0.pslverr, bus0.prdata}, 16'h0283);
      @(negedge pclk);
      bus0.psel = 0; bus0.penable = 0;

`ifdef DECODER_CNT_EN
      pulse_reset();
      wr(8'h00, 8'h01, 1'b0, "cnt_a");
      wr(8'h00, 8'h80, 1'b0, "cnt_b");
      wr(8'h00, 8'h00, 1'b0, "cnt_c");
      wr(8'h00, 8'h10, 1'b0, "cnt_d");
      rd(8'h03, 8'h03, 1'b0, "cnt_three");
      for (int k = 0; k < 253; k++) begin
         v = 8'h01 << (k % 8);
         wr(8'h00, v, 1'b0, "cnt_fill");
      end
      rd(8'h03, 8'h00, 1'b0, "cnt_wrap");
      wr(8'h03, 8'h12, 1'b1, "cnt_wr_err");
`else
      rd(8'h03, 8'h00, 1'b1, "cnt_absent_rd");
      wr(8'h03, 8'h12, 1'b1, "cnt_absent_wr");
`endif

      check("sb_empty", 16'(sb.size()), 16'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
